id_ex_hazard_stage: RTL
=======================

# id_ex_hazard_stage

ID/EX pipeline register of the 16-bit 5-stage core, with integrated load-use hazard detection. It captures decoded operands and control from the ID stage and presents registered `id_ex_*` fields to the EX stage and to the EX-stage forwarding unit. It inserts exactly one bubble on a load-use dependency, squashes on branch flush, and freezes on downstream memory stall. It also maintains a saturating stall counter for performance monitoring.

## Interface
Parameters:
- `DATA_W`, 16, datapath width
- `REG_W`, 3, register index width (8 registers, r0 reads as zero and is never written)
- `ALU_OP_W`, 4, ALU opcode width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `id_valid` in 1: ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd` in REG_W: source and destination indices
- `id_uses_rs`, `id_uses_rt` in 1: instruction actually reads rs / rt
- `id_rs_data`, `id_rt_data`, `id_imm` in DATA_W: operands and sign-extended immediate
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_alu_src` in 1: control
- `id_alu_op` in ALU_OP_W
- `ex_flush` in 1: branch taken / redirect resolved in EX
- `mem_busy` in 1: downstream stall; whole pipe freezes
- `stall_if_id` out 1: hold PC and IF/ID this cycle
- `id_ex_valid` out 1
- `id_ex_rs`, `id_ex_rt`, `id_ex_rd` out REG_W
- `id_ex_rs_data`, `id_ex_rt_data`, `id_ex_imm` out DATA_W
- `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write`, `id_ex_mem_to_reg`, `id_ex_alu_src` out 1
- `id_ex_alu_op` out ALU_OP_W
- `stall_count` out 16: number of load-use bubbles inserted, saturating

## Operation
- Hazard detection (combinational): `load_use = id_valid & id_ex_valid & id_ex_mem_read & (id_ex_rd != 0) & ((id_uses_rs & id_rs == id_ex_rd) | (id_uses_rt & id_rt == id_ex_rd))`.
- `stall_if_id = (load_use & ~ex_flush) | mem_busy`.
- Register update priority at each edge:
  - `reset`: all outputs 0, including `stall_count`.
  - `ex_flush`: load a bubble. Flush wins over `mem_busy` and `load_use`.
  - `mem_busy`: hold all registers unchanged.
  - `load_use`: load a bubble and increment `stall_count`.
  - Otherwise: capture ID inputs, with `id_ex_valid = id_valid`.
- Bubble: `id_ex_valid = 0` and all control bits and `id_ex_alu_op` = 0. Index and data fields are also 0, so a bubble can never match in forwarding.
- Control outputs are gated: an invalid ID instruction (`id_valid = 0`) is captured with all control bits forced to 0.
- `id_rd == 0` with `id_reg_write = 1` is captured as is; the forwarding unit masks rd = 0.
- `stall_count` saturates at 16'hFFFF and does not wrap. It does not count freezes or flushes.

## Timing
- Latency: 1 cycle from ID inputs to `id_ex_*` outputs.
- `stall_if_id` is combinational from registered state plus ID/flush/busy inputs, so it is valid in the same cycle.
- A load-use stall lasts exactly one cycle: after the bubble, `id_ex_mem_read = 0`, so `load_use` deasserts. The held instruction enters on the following edge.
- When `load_use` and `mem_busy` are both asserted, the register freezes. The bubble is inserted on the first cycle `mem_busy` is low, and the counter is incremented once.
- Reset asserted mid-stall clears everything. `stall_if_id` then follows the equation, and is 0 unless `mem_busy` is high.

## Structure
- Shared package `cpu_pkg`: `REG_W`, `DATA_W`, `ALU_OP_W`, `ALU_NOP` = 0, and a packed control struct or bundle constant for the bubble.
- Natural sub-module: `load_use_detector`, which is purely combinational and computes `load_use`. The register and counter stay in the top module.

## Test plan
- Straight-line: feed `ADD r1,r2,r3` with `id_valid` = 1. Next cycle `id_ex_rd` = 1, `id_ex_reg_write` = 1, `id_ex_valid` = 1, and `stall_if_id` is 0 throughout.
- Load-use: `LW r2` is in EX and `ADD r4,r2,r5` is in ID with `uses_rs` = 1. Expect `stall_if_id` = 1 for one cycle, a bubble in ID/EX, then the ADD on the next edge, and `stall_count` = 1.
- No false hazard: `LW r0` in EX with rs = 0 in ID gives no stall. `LW r2` with an ID instruction that has `uses_rt` = 0 but rt = 2 also gives no stall.
- Flush priority: raise `ex_flush` and `load_use` together. Expect a bubble, `stall_if_id` = 0, and `stall_count` unchanged.
- Freeze: hold `mem_busy` = 1 for 3 cycles. Expect outputs unchanged and `stall_if_id` = 1. When it releases with `load_use` pending, expect a single bubble and a count increment of exactly 1.
- Saturation and reset: preload the count to 16'hFFFE and force 3 load-use events. The count sticks at 16'hFFFF. Assert `reset` for one cycle; all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU no-op encoding and the bubble control bundle for the 5-stage core
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 3;
  localparam int ALU_OP_W = 4;
  localparam logic [ALU_OP_W-1:0] ALU_NOP = '0;
  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    mem_to_reg: 1'b0, alu_src: 1'b0, alu_op: ALU_NOP
  };
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detector
  import cpu_pkg::*;
#(
  parameter int REG_W_P = REG_W
) (
  input  logic               id_valid,
  input  logic [REG_W_P-1:0] id_rs,
  input  logic [REG_W_P-1:0] id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [REG_W_P-1:0] ex_rd,
  output logic               load_use
);
  logic rs_hit, rt_hit;
  // r0 is never written, so a load targeting it cannot create a dependency
  always_comb begin
    rs_hit   = id_uses_rs & (id_rs == ex_rd);
    rt_hit   = id_uses_rt & (id_rt == ex_rd);
    load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) & (rs_hit | rt_hit);
  end
endmodule

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use bubble insertion, flush, freeze and stall counter
module id_ex_hazard_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W_P   = DATA_W,
  parameter int REG_W_P    = REG_W,
  parameter int ALU_OP_W_P = ALU_OP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_W_P-1:0]    id_rs,
  input  logic [REG_W_P-1:0]    id_rt,
  input  logic [REG_W_P-1:0]    id_rd,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [DATA_W_P-1:0]   id_rs_data,
  input  logic [DATA_W_P-1:0]   id_rt_data,
  input  logic [DATA_W_P-1:0]   id_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic [ALU_OP_W_P-1:0] id_alu_op,
  input  logic                  ex_flush,
  input  logic                  mem_busy,
  output logic                  stall_if_id,
  output logic                  id_ex_valid,
  output logic [REG_W_P-1:0]    id_ex_rs,
  output logic [REG_W_P-1:0]    id_ex_rt,
  output logic [REG_W_P-1:0]    id_ex_rd,
  output logic [DATA_W_P-1:0]   id_ex_rs_data,
  output logic [DATA_W_P-1:0]   id_ex_rt_data,
  output logic [DATA_W_P-1:0]   id_ex_imm,
  output logic                  id_ex_reg_write,
  output logic                  id_ex_mem_read,
  output logic                  id_ex_mem_write,
  output logic                  id_ex_mem_to_reg,
  output logic                  id_ex_alu_src,
  output logic [ALU_OP_W_P-1:0] id_ex_alu_op,
  output logic [15:0]           stall_count
);
  typedef struct packed {
    logic                valid;
    logic [REG_W_P-1:0]  rs;
    logic [REG_W_P-1:0]  rt;
    logic [REG_W_P-1:0]  rd;
    logic [DATA_W_P-1:0] rs_data;
    logic [DATA_W_P-1:0] rt_data;
    logic [DATA_W_P-1:0] imm;
    ctrl_t               ctrl;
  } entry_t;
  localparam entry_t BUBBLE = '{
    valid: 1'b0, rs: '0, rt: '0, rd: '0,
    rs_data: '0, rt_data: '0, imm: '0, ctrl: CTRL_BUBBLE
  };
  entry_t      id_ex_d, id_ex_q, id_in;
  logic [15:0] stall_count_d, stall_count_q;
  logic        load_use;
  load_use_detector #(.REG_W_P(REG_W_P)) u_load_use_detector (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (id_ex_q.valid),
    .ex_mem_read (id_ex_q.ctrl.mem_read),
    .ex_rd       (id_ex_q.rd),
    .load_use    (load_use)
  );
  // next ID/EX contents: flush beats freeze beats load-use bubble beats normal capture
  always_comb begin
    id_in = '{
      valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
      rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
      ctrl: id_valid ? ctrl_t'{id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op}
                     : CTRL_BUBBLE
    };
    id_ex_d       = ex_flush ? BUBBLE : mem_busy ? id_ex_q : load_use ? BUBBLE : id_in;
    stall_count_d = (~ex_flush & ~mem_busy & load_use & ~&stall_count_q) ? stall_count_q + 16'd1 : stall_count_q;
    stall_if_id   = (load_use & ~ex_flush) | mem_busy;
  end
  // pipeline register and saturating bubble counter
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q       <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      id_ex_q       <= id_ex_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign id_ex_valid      = id_ex_q.valid;
  assign id_ex_rs         = id_ex_q.rs;
  assign id_ex_rt         = id_ex_q.rt;
  assign id_ex_rd         = id_ex_q.rd;
  assign id_ex_rs_data    = id_ex_q.rs_data;
  assign id_ex_rt_data    = id_ex_q.rt_data;
  assign id_ex_imm        = id_ex_q.imm;
  assign id_ex_reg_write  = id_ex_q.ctrl.reg_write;
  assign id_ex_mem_read   = id_ex_q.ctrl.mem_read;
  assign id_ex_mem_write  = id_ex_q.ctrl.mem_write;
  assign id_ex_mem_to_reg = id_ex_q.ctrl.mem_to_reg;
  assign id_ex_alu_src    = id_ex_q.ctrl.alu_src;
  assign id_ex_alu_op     = id_ex_q.ctrl.alu_op;
  assign stall_count      = stall_count_q;
endmodule
